fixed_point_iterative_accumulator: RTL and testbench
====================================================

// Module: fixed_point_iterative_accumulator
// PURPOSE
//  Downstream consumer of the iterative fixed-point multiplier. Accepts a stream of
//  n-bit fixed-point products over val/rdy, accumulates one product per accepted beat
//  in an (n+g)-bit guarded register, and emits one saturated n-bit sum plus an
//  overflow flag per frame. A frame ends on a beat with recv_last=1 or at max_terms.
//  Used to build dot products / FIR taps from back-to-back multiplier results.
// PARAMETERS
//  n          32   data width (same fixed-point format as multiplier output)
//  d          16   fractional bits; format tag only, no effect on arithmetic
//  sign       1    1 = two's-complement operands/sum, 0 = unsigned
//  max_terms  256  max beats per frame, >=2; guard bits g = $clog2(max_terms)
// PORTS
//  clk        in   1    clock, all state updates on posedge
//  reset      in   1    asynchronous, active-low reset
//  recv_val   in   1    input beat valid
//  recv_rdy   out  1    block can take a beat
//  recv_msg   in   n    product to accumulate
//  recv_last  in   1    beat is final term of frame
//  send_val   out  1    sum valid
//  send_rdy   in   1    consumer takes sum
//  send_msg   out  n    saturated frame sum
//  send_ovf   out  1    1 = sum was clamped
// BEHAVIOUR
//  - Reset (reset=0, async): state=ACC, acc=0, cnt=0. recv_rdy=1 (from state),
//    send_val=0, send_msg=0, send_ovf=0. Mid-frame reset discards partial sum.
//  - States: ACC (recv_rdy=1, send_val=0); DONE (recv_rdy=0, send_val=1).
//  - ACC: beat accepted iff recv_val&recv_rdy; acc <= acc + ext(recv_msg), ext =
//    sign-extend (sign=1) or zero-extend (sign=0) to n+g bits; cnt <= cnt+1.
//    Go to DONE on accepted beat with recv_last=1 OR cnt==max_terms-1 (forced end).
//    No beat: acc/cnt hold.
//  - Entering DONE: register send_msg=sat(acc_next), send_ovf=clamp flag; latency =
//    1 cycle from last accepted beat to send_val=1. Single-beat frame is legal.
//  - DONE: send_msg/send_ovf held stable while send_val=1 & send_rdy=0.
//    On send_rdy=1: acc<=0, cnt<=0, state<=ACC; recv_rdy=1 next cycle (no same-cycle
//    accept in DONE; recv_rdy not combinationally dependent on send_rdy).
//  - sat(): sign=1: > 2^(n-1)-1 -> {0,1..1}; < -2^(n-1) -> {1,0..0}.
//    sign=0: >= 2^n -> all ones. Else low n bits. ovf=1 iff clamped.
//  - g guard bits guarantee no internal wrap for <= max_terms beats; acc never wraps.
//  - recv_last ignored when recv_val=0. Values of recv_msg ignored when not accepted.
// STRUCTURE
//  - fixed_point_pkg: typedef enum logic {ACC, DONE} fxp_acc_state_t.
//  - Sub-module fixed_point_saturate #(n,g,sign): combinational (n+g)->n clamp + ovf.
//  - Top: state reg, cnt reg [$clog2(max_terms)-1:0], acc reg [n+g-1:0], output regs.
// TESTING  (n=32, d=16, sign=1 unless noted)
//  - Beats 0x00018000, 0x00024000, 0xFFFF4000(last) -> send_msg 0x00030000, ovf 0,
//    send_val 1 cycle after last beat.
//  - Beats 0x7FFF0000, 0x7FFF0000(last) -> send_msg 0x7FFFFFFF, ovf 1; beats
//    0x80000000 x2 -> 0x80000000, ovf 1; sign=0 0xFFFFFFFF x2 -> 0xFFFFFFFF, ovf 1.
//  - max_terms=4, four beats 0x00010000 with last=0 -> frame forced, send_msg
//    0x00040000; fifth beat starts new frame.
//  - Hold send_rdy=0 for 5 cycles in DONE -> send_val=1, msg stable, recv_rdy=0;
//    recv_val=1 throughout causes no accumulation; release -> next frame starts at 0.
//  - Reset pulse after 2 of 3 beats -> all outputs at reset values immediately;
//    following frame 0x00010000(last) -> 0x00010000.
//  - Random val/rdy throttling, 1000 frames vs golden saturating sum model.

Source files
------------

// File: rtl/fixed_point_pkg.sv
// Shared types and helpers for the fixed-point accumulator.
package fixed_point_pkg;

    // ACC: taking beats into the frame sum; DONE: presenting the frame result.
    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } fxp_acc_state_t;

    // Headroom needed so that max_terms full-scale terms can never wrap the sum.
    function automatic int unsigned guard_bits(int unsigned max_terms);
        return $clog2(max_terms);
    endfunction

endpackage

// File: rtl/fixed_point_saturate.sv
// Clamps an (n+g)-bit guarded sum into n bits and flags when clamping happened.
module fixed_point_saturate
    import fixed_point_pkg::*;
#(
    parameter int unsigned n    = 32,
    parameter int unsigned g    = 8,
    parameter bit          sign = 1'b1
) (
    input  logic [n+g-1:0] acc_i,
    output logic [n-1:0]   sat_o,
    output logic           ovf_o
);

    // Signed: value fits iff the top g+1 bits are all copies of the sign bit.
    // Unsigned: value fits iff the g guard bits are all zero.
    always_comb begin
        sat_o = acc_i[n-1:0];
        ovf_o = 1'b0;
        if (sign) begin
            if (acc_i[n+g-1:n-1] != {(g+1){acc_i[n+g-1]}}) begin
                ovf_o = 1'b1;
                sat_o = acc_i[n+g-1] ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
            end
        end else begin
            if (|acc_i[n+g-1:n]) begin
                ovf_o = 1'b1;
                sat_o = {n{1'b1}};
            end
        end
    end

endmodule

// File: rtl/fixed_point_iterative_accumulator.sv
// Accumulates a val/rdy stream of fixed-point products into one saturated sum per frame.
module fixed_point_iterative_accumulator
    import fixed_point_pkg::*;
#(
    parameter int unsigned n         = 32,
    parameter int unsigned d         = 16,
    parameter bit          sign      = 1'b1,
    parameter int unsigned max_terms = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         recv_val,
    output logic         recv_rdy,
    input  logic [n-1:0] recv_msg,
    input  logic         recv_last,
    output logic         send_val,
    input  logic         send_rdy,
    output logic [n-1:0] send_msg,
    output logic         send_ovf
);

    localparam int unsigned g = guard_bits(max_terms);
    localparam int unsigned W = n + g;
    localparam logic [g-1:0] LastCnt = g'(max_terms - 1);
    localparam logic [g-1:0] CntOne  = g'(1);

    // d only tags the binary point; reject formats that cannot exist.
    if (d > n) begin : g_bad_frac
        $error("fractional bits exceed data width");
    end
    if (max_terms < 2) begin : g_bad_terms
        $error("max_terms must be at least 2");
    end

    fxp_acc_state_t state_q, state_d;
    logic [g-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [n-1:0]   msg_q, msg_d;
    logic           ovf_q, ovf_d;

    logic [W-1:0]   msg_ext;
    logic [W-1:0]   acc_sum;
    logic [n-1:0]   sat_val;
    logic           sat_ovf;

    assign msg_ext = sign ? {{g{recv_msg[n-1]}}, recv_msg} : {{g{1'b0}}, recv_msg};
    assign acc_sum = acc_q + msg_ext;

    fixed_point_saturate #(
        .n    (n),
        .g    (g),
        .sign (sign)
    ) u_saturate (
        .acc_i (acc_sum),
        .sat_o (sat_val),
        .ovf_o (sat_ovf)
    );

    // Handshakes come straight from state so neither ready depends on the other side.
    assign recv_rdy = (state_q == ACC);
    assign send_val = (state_q == DONE);
    assign send_msg = msg_q;
    assign send_ovf = ovf_q;

    // Next-state: accumulate accepted beats, close the frame, and drain the result.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        msg_d   = msg_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ACC: begin
                if (recv_val) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + CntOne;
                    // Forced end keeps the count inside the guard-bit headroom.
                    if (recv_last || (cnt_q == LastCnt)) begin
                        state_d = DONE;
                        msg_d   = sat_val;
                        ovf_d   = sat_ovf;
                    end
                end
            end
            DONE: begin
                if (send_rdy) begin
                    state_d = ACC;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = ACC;
        endcase
    end

    // State and datapath registers; reset drops any partial frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ACC;
            cnt_q   <= '0;
            acc_q   <= '0;
            msg_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            msg_q   <= msg_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_fixed_point_iterative_accumulator.sv
// Bench: three accumulator instances (signed/256, unsigned/256, signed/4) checked
// against a saturating-sum model every cycle plus hand-computed directed results.
module tb_fixed_point_iterative_accumulator;

    localparam bit MSign[3] = '{1'b1, 1'b0, 1'b1};
    localparam int MMax[3]  = '{256, 256, 4};
    localparam longint SMax = 64'sd2147483647;
    localparam longint SMin = -64'sd2147483648;
    localparam longint UMax = 64'sd4294967295;

    logic clk;
    logic rst_n;
    logic        rv[3];
    logic        rl[3];
    logic        sr[3];
    logic [31:0] rm[3];
    logic        rr[3];
    logic        sv[3];
    logic        so[3];
    logic [31:0] sm[3];

    int  n_tests;
    int  n_fail;
    bit  chk_en;
    bit  rnd;

    fixed_point_iterative_accumulator #(
        .n (32), .d (16), .sign (1'b1), .max_terms (256)
    ) u_dut_s (
        .clk (clk), .reset (rst_n),
        .recv_val (rv[0]), .recv_rdy (rr[0]), .recv_msg (rm[0]), .recv_last (rl[0]),
        .send_val (sv[0]), .send_rdy (sr[0]), .send_msg (sm[0]), .send_ovf (so[0])
    );

    fixed_point_iterative_accumulator #(
        .n (32), .d (16), .sign (1'b0), .max_terms (256)
    ) u_dut_u (
        .clk (clk), .reset (rst_n),
        .recv_val (rv[1]), .recv_rdy (rr[1]), .recv_msg (rm[1]), .recv_last (rl[1]),
        .send_val (sv[1]), .send_rdy (sr[1]), .send_msg (sm[1]), .send_ovf (so[1])
    );

    fixed_point_iterative_accumulator #(
        .n (32), .d (16), .sign (1'b1), .max_terms (4)
    ) u_dut_m4 (
        .clk (clk), .reset (rst_n),
        .recv_val (rv[2]), .recv_rdy (rr[2]), .recv_msg (rm[2]), .recv_last (rl[2]),
        .send_val (sv[2]), .send_rdy (sr[2]), .send_msg (sm[2]), .send_ovf (so[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic longint ext_val(int i, logic [31:0] m);
        if (MSign[i]) return longint'($signed(m));
        return longint'({32'b0, m});
    endfunction

    // Returns {ovf, msg} for a mathematically exact frame sum.
    function automatic logic [32:0] sat_of(int i, longint s);
        if (MSign[i]) begin
            if (s > SMax) return {1'b1, 32'h7FFF_FFFF};
            if (s < SMin) return {1'b1, 32'h8000_0000};
        end else begin
            if (s > UMax) return {1'b1, 32'hFFFF_FFFF};
        end
        return {1'b0, s[31:0]};
    endfunction

    bit          m_busy[3];
    longint      m_sum[3];
    int          m_terms[3];
    logic [32:0] m_exp[3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_busy[i]  <= 1'b0;
                m_sum[i]   <= 0;
                m_terms[i] <= 0;
                m_exp[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!m_busy[i]) begin
                    if (rv[i]) begin
                        m_sum[i]   <= m_sum[i] + ext_val(i, rm[i]);
                        m_terms[i] <= m_terms[i] + 1;
                        if (rl[i] || (m_terms[i] + 1 == MMax[i])) begin
                            m_busy[i] <= 1'b1;
                            m_exp[i]  <= sat_of(i, m_sum[i] + ext_val(i, rm[i]));
                        end
                    end
                end else if (sr[i]) begin
                    m_busy[i]  <= 1'b0;
                    m_sum[i]   <= 0;
                    m_terms[i] <= 0;
                end
            end
        end
    end

    task automatic check(string nm, int i, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h at %0t", nm, i, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(string nm, int i);
        n_tests++;
        n_fail++;
        $display("FAIL %s[%0d]: timed out waiting for handshake at %0t", nm, i, $time);
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                check("model_recv_rdy", i, 64'(rr[i]), 64'(!m_busy[i]));
                check("model_send_val", i, 64'(sv[i]), 64'(m_busy[i]));
                if (m_busy[i]) begin
                    check("model_send_msg", i, 64'(sm[i]), 64'(m_exp[i][31:0]));
                    check("model_send_ovf", i, 64'(so[i]), 64'(m_exp[i][32]));
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd) sr[0] = 1'($urandom_range(0, 1));
    endtask

    task automatic beat(int i, logic [31:0] m, logic l);
        logic was;
        rv[i] = 1'b1;
        rm[i] = m;
        rl[i] = l;
        for (int k = 0; k < 300; k++) begin
            was = rr[i];
            tick();
            if (was) begin
                rv[i] = 1'b0;
                rl[i] = 1'($urandom_range(0, 1));
                rm[i] = $urandom;
                return;
            end
        end
        timeout_fail("beat_accept", i);
        rv[i] = 1'b0;
    endtask

    task automatic take(int i, logic [31:0] em, logic eo, string nm);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (sv[i]) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        if (!got) begin
            timeout_fail(nm, i);
        end else begin
            check({nm, "_msg"}, i, 64'(sm[i]), 64'(em));
            check({nm, "_ovf"}, i, 64'(so[i]), 64'(eo));
        end
        sr[i] = 1'b1;
        tick();
        sr[i] = 1'b0;
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 32'h0003_FFFF));
            1:       return 32'h0 - 32'($urandom_range(0, 32'h0003_FFFF));
            2:       return 32'h7000_0000 + 32'($urandom_range(0, 32'h0FFF_FFFF));
            default: return 32'h8000_0000 + 32'($urandom_range(0, 32'h0FFF_FFFF));
        endcase
    endfunction

    // Global watchdog so the run always ends.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        chk_en  = 1'b0;
        rnd     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rv[i] = 1'b0; rl[i] = 1'b0; sr[i] = 1'b0; rm[i] = '0;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Reset state
        for (int i = 0; i < 3; i++) begin
            check("reset_recv_rdy", i, 64'(rr[i]), 64'd1);
            check("reset_send_val", i, 64'(sv[i]), 64'd0);
            check("reset_send_msg", i, 64'(sm[i]), 64'd0);
            check("reset_send_ovf", i, 64'(so[i]), 64'd0);
        end
        rst_n = 1'b1;
        tick();

        // 1.5 + 2.25 - 0.75 = 3.0, result one cycle after the last beat
        beat(0, 32'h0001_8000, 1'b0);
        beat(0, 32'h0002_4000, 1'b0);
        beat(0, 32'hFFFF_4000, 1'b1);
        check("t1_latency", 0, 64'(sv[0]), 64'd1);
        take(0, 32'h0003_0000, 1'b0, "t1_sum");

        // Signed clamping both ways and the exact positive limit
        beat(0, 32'h7FFF_0000, 1'b0);
        beat(0, 32'h7FFF_0000, 1'b1);
        take(0, 32'h7FFF_FFFF, 1'b1, "pos_clamp");
        beat(0, 32'h8000_0000, 1'b0);
        beat(0, 32'h8000_0000, 1'b1);
        take(0, 32'h8000_0000, 1'b1, "neg_clamp");
        beat(0, 32'h7FFF_FFFF, 1'b0);
        beat(0, 32'h0000_0000, 1'b1);
        take(0, 32'h7FFF_FFFF, 1'b0, "pos_edge_fit");
        beat(0, 32'h7FFF_FFFF, 1'b0);
        beat(0, 32'h0000_0001, 1'b1);
        take(0, 32'h7FFF_FFFF, 1'b1, "pos_edge_over");
        beat(0, 32'hFFFF_0000, 1'b1);
        take(0, 32'hFFFF_0000, 1'b0, "single_beat_neg");

        // Unsigned clamping and exact fit
        beat(1, 32'hFFFF_FFFF, 1'b0);
        beat(1, 32'hFFFF_FFFF, 1'b1);
        take(1, 32'hFFFF_FFFF, 1'b1, "u_clamp");
        beat(1, 32'h8000_0000, 1'b0);
        beat(1, 32'h7FFF_FFFF, 1'b1);
        take(1, 32'hFFFF_FFFF, 1'b0, "u_edge_fit");
        beat(1, 32'h8000_0000, 1'b0);
        beat(1, 32'h8000_0000, 1'b1);
        take(1, 32'hFFFF_FFFF, 1'b1, "u_edge_over");

        // Forced frame end at max_terms=4, fifth beat opens a new frame
        for (int k = 0; k < 4; k++) beat(2, 32'h0001_0000, 1'b0);
        check("forced_end_val", 2, 64'(sv[2]), 64'd1);
        take(2, 32'h0004_0000, 1'b0, "forced_sum");
        beat(2, 32'h0001_0000, 1'b1);
        take(2, 32'h0001_0000, 1'b0, "after_forced");

        // Backpressure in DONE: result held, no accumulation while recv_val stays high
        beat(0, 32'h0005_0000, 1'b1);
        rv[0] = 1'b1;
        rm[0] = 32'h1111_0000;
        rl[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("hold_send_val", 0, 64'(sv[0]), 64'd1);
            check("hold_recv_rdy", 0, 64'(rr[0]), 64'd0);
            check("hold_send_msg", 0, 64'(sm[0]), 64'h0005_0000);
        end
        rv[0] = 1'b0;
        sr[0] = 1'b1;
        tick();
        sr[0] = 1'b0;
        check("release_recv_rdy", 0, 64'(rr[0]), 64'd1);
        check("release_send_val", 0, 64'(sv[0]), 64'd0);
        beat(0, 32'h0000_0100, 1'b1);
        take(0, 32'h0000_0100, 1'b0, "after_hold");

        // Mid-frame reset discards the partial sum and clears outputs at once
        beat(0, 32'h0001_0000, 1'b0);
        beat(0, 32'h0002_0000, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midreset_recv_rdy", 0, 64'(rr[0]), 64'd1);
        check("midreset_send_val", 0, 64'(sv[0]), 64'd0);
        check("midreset_send_msg", 0, 64'(sm[0]), 64'd0);
        check("midreset_send_ovf", 0, 64'(so[0]), 64'd0);
        tick();
        rst_n = 1'b1;
        beat(0, 32'h0001_0000, 1'b1);
        take(0, 32'h0001_0000, 1'b0, "after_reset");

        // Random throttling on both sides; the model checks every cycle
        rnd = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) begin
                repeat ($urandom_range(0, 2)) tick();
                beat(0, rand_val(), 1'(b == len - 1));
            end
        end
        rnd = 1'b0;
        sr[0] = 1'b1;
        for (int k = 0; k < 10 && sv[0]; k++) tick();
        sr[0] = 1'b0;
        tick();
        check("drain_send_val", 0, 64'(sv[0]), 64'd0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
